// File: rtl/dm_amo_sequencer_if.sv
// Bundles the two processor AMO request ports and the data-memory read/write ports.
// The sequencer connects through 'master'; processors and memory connect through 'slave'.
interface dm_amo_sequencer_if #(
  parameter int unsigned DOUBLEWORD_WIDTH = 64,
  parameter int unsigned DATA_MEMORY_SIZE = 256,
  parameter int unsigned ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
  parameter int unsigned DATA_TYPE_WIDTH  = 2
);
  logic                        amo_req_p1;
  logic                        amo_req_p2;
  logic [2:0]                  amo_op_p1;
  logic [2:0]                  amo_op_p2;
  logic [ADDR_WIDTH_DM-1:0]    amo_addr_p1;
  logic [ADDR_WIDTH_DM-1:0]    amo_addr_p2;
  logic [DATA_TYPE_WIDTH-1:0]  amo_type_p1;
  logic [DATA_TYPE_WIDTH-1:0]  amo_type_p2;
  logic [DOUBLEWORD_WIDTH-1:0] amo_src_p1;
  logic [DOUBLEWORD_WIDTH-1:0] amo_src_p2;
  logic                        amo_done_p1;
  logic                        amo_done_p2;
  logic [DOUBLEWORD_WIDTH-1:0] amo_old_p1;
  logic [DOUBLEWORD_WIDTH-1:0] amo_old_p2;
  logic                        amo_active;

  logic [DOUBLEWORD_WIDTH-1:0] data_bus_rd_dm;
  logic [ADDR_WIDTH_DM-1:0]    addr_rd_dm;
  logic [DATA_TYPE_WIDTH-1:0]  data_type_rd_dm;
  logic                        rd_idle_dm;
  logic                        rd_ins_dm;
  logic [DOUBLEWORD_WIDTH-1:0] data_bus_wr_dm;
  logic [ADDR_WIDTH_DM-1:0]    addr_wr_dm;
  logic [DATA_TYPE_WIDTH-1:0]  data_type_wr_dm;
  logic                        wr_idle_dm;
  logic                        wr_ins_dm;

  modport master (
    input  amo_req_p1, amo_req_p2, amo_op_p1, amo_op_p2,
    input  amo_addr_p1, amo_addr_p2, amo_type_p1, amo_type_p2,
    input  amo_src_p1, amo_src_p2,
    output amo_done_p1, amo_done_p2, amo_old_p1, amo_old_p2, amo_active,
    input  data_bus_rd_dm, rd_idle_dm, wr_idle_dm,
    output addr_rd_dm, data_type_rd_dm, rd_ins_dm,
    output data_bus_wr_dm, addr_wr_dm, data_type_wr_dm, wr_ins_dm
  );

  modport slave (
    output amo_req_p1, amo_req_p2, amo_op_p1, amo_op_p2,
    output amo_addr_p1, amo_addr_p2, amo_type_p1, amo_type_p2,
    output amo_src_p1, amo_src_p2,
    input  amo_done_p1, amo_done_p2, amo_old_p1, amo_old_p2, amo_active,
    output data_bus_rd_dm, rd_idle_dm, wr_idle_dm,
    input  addr_rd_dm, data_type_rd_dm, rd_ins_dm,
    input  data_bus_wr_dm, addr_wr_dm, data_type_wr_dm, wr_ins_dm
  );
endinterface

// File: rtl/dm_amo_sequencer.sv
// Round-robin AMO sequencer: arbitrates two processors, then runs a back-to-back
// read -> modify -> write on the shared data-memory port and returns the old value.
module dm_amo_sequencer #(
  parameter int unsigned DOUBLEWORD_WIDTH = 64,
  parameter int unsigned DATA_MEMORY_SIZE = 256,
  parameter int unsigned ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
  parameter int unsigned DATA_TYPE_WIDTH  = 2
) (
  input logic                clk,
  input logic                rst,
  dm_amo_sequencer_if.master bus
);
  localparam int unsigned DW = DOUBLEWORD_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_GAP,
    S_RD_WAIT,
    S_EXEC,
    S_WR_ISSUE,
    S_WR_GAP,
    S_WR_WAIT,
    S_DONE
  } state_e;

  state_e                     state_q;
  logic                       last_p2_q;
  logic                       gnt_p2_q;
  logic [2:0]                 op_q;
  logic [ADDR_WIDTH_DM-1:0]   addr_q;
  logic [DATA_TYPE_WIDTH-1:0] type_q;
  logic [DW-1:0]              src_q;
  logic [DW-1:0]              old_q;
  logic [DW-1:0]              wdata_q;
  logic                       rd_ins_q;
  logic                       wr_ins_q;
  logic                       done_p1_q;
  logic                       done_p2_q;
  logic [DW-1:0]              old_p1_q;
  logic [DW-1:0]              old_p2_q;
  logic                       active_q;

  logic                       gnt_valid;
  logic                       gnt_p2_d;
  logic [2:0]                 op_d;
  logic [ADDR_WIDTH_DM-1:0]   addr_d;
  logic [DATA_TYPE_WIDTH-1:0] type_d;
  logic [DW-1:0]              src_d;
  logic [DW-1:0]              mask_c;
  logic [DW-1:0]              res_c;
  logic [DW-1:0]              wdata_d;

  function automatic logic [DW-1:0] size_mask(input logic [DATA_TYPE_WIDTH-1:0] t);
    case (t[1:0])
      2'b00:   return DW'(8'hFF);
      2'b01:   return DW'(16'hFFFF);
      2'b10:   return DW'(32'hFFFF_FFFF);
      default: return '1;
    endcase
  endfunction

  function automatic logic [DW-1:0] sext(input logic [DW-1:0] v,
                                         input logic [DATA_TYPE_WIDTH-1:0] t);
    logic [DW-1:0] m;
    logic          s;
    m = size_mask(t);
    case (t[1:0])
      2'b00:   s = v[7];
      2'b01:   s = v[15];
      2'b10:   s = v[31];
      default: s = v[DW-1];
    endcase
    return (v & m) | (s ? ~m : '0);
  endfunction

  // Tie goes to whichever processor was not granted last.
  always_comb begin
    gnt_valid = bus.amo_req_p1 | bus.amo_req_p2;
    gnt_p2_d  = bus.amo_req_p2 & (~bus.amo_req_p1 | ~last_p2_q);
    op_d      = gnt_p2_d ? bus.amo_op_p2   : bus.amo_op_p1;
    addr_d    = gnt_p2_d ? bus.amo_addr_p2 : bus.amo_addr_p1;
    type_d    = gnt_p2_d ? bus.amo_type_p2 : bus.amo_type_p1;
    src_d     = gnt_p2_d ? bus.amo_src_p2  : bus.amo_src_p1;
  end

  // Operands are held sign-extended, so signed ops and ADD work on the full width;
  // MAXU and the final write mask back down to the access size.
  always_comb begin
    mask_c = size_mask(type_q);
    res_c  = '0;
    case (op_q)
      3'b000:  res_c = src_q;
      3'b001:  res_c = old_q + src_q;
      3'b010:  res_c = old_q & src_q;
      3'b011:  res_c = old_q | src_q;
      3'b100:  res_c = old_q ^ src_q;
      3'b101:  res_c = ($signed(old_q) > $signed(src_q)) ? old_q : src_q;
      3'b110:  res_c = ($signed(old_q) < $signed(src_q)) ? old_q : src_q;
      default: res_c = ((old_q & mask_c) > (src_q & mask_c)) ? old_q : src_q;
    endcase
    wdata_d = res_c & mask_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_p2_q <= 1'b1;
      gnt_p2_q  <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      type_q    <= '0;
      src_q     <= '0;
      old_q     <= '0;
      wdata_q   <= '0;
      rd_ins_q  <= 1'b0;
      wr_ins_q  <= 1'b0;
      done_p1_q <= 1'b0;
      done_p2_q <= 1'b0;
      old_p1_q  <= '0;
      old_p2_q  <= '0;
      active_q  <= 1'b0;
    end else begin
      rd_ins_q  <= 1'b0;
      wr_ins_q  <= 1'b0;
      done_p1_q <= 1'b0;
      done_p2_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            gnt_p2_q  <= gnt_p2_d;
            last_p2_q <= gnt_p2_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            src_q     <= sext(src_d, type_d);
            active_q  <= 1'b1;
            state_q   <= S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          if (bus.rd_idle_dm) begin
            rd_ins_q <= 1'b1;
            state_q  <= S_RD_GAP;
          end
        end
        S_RD_GAP: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (bus.rd_idle_dm) begin
            old_q   <= sext(bus.data_bus_rd_dm, type_q);
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          wdata_q <= wdata_d;
          state_q <= S_WR_ISSUE;
        end
        S_WR_ISSUE: begin
          if (bus.wr_idle_dm) begin
            wr_ins_q <= 1'b1;
            state_q  <= S_WR_GAP;
          end
        end
        S_WR_GAP: state_q <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (bus.wr_idle_dm) begin
            if (gnt_p2_q) begin
              done_p2_q <= 1'b1;
              old_p2_q  <= old_q;
            end else begin
              done_p1_q <= 1'b1;
              old_p1_q  <= old_q;
            end
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          active_q <= 1'b0;
          addr_q   <= '0;
          type_q   <= '0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.amo_done_p1     = done_p1_q;
  assign bus.amo_done_p2     = done_p2_q;
  assign bus.amo_old_p1      = old_p1_q;
  assign bus.amo_old_p2      = old_p2_q;
  assign bus.amo_active      = active_q;
  assign bus.addr_rd_dm      = addr_q;
  assign bus.data_type_rd_dm = type_q;
  assign bus.rd_ins_dm       = rd_ins_q;
  assign bus.data_bus_wr_dm  = wdata_q;
  assign bus.addr_wr_dm      = addr_q;
  assign bus.data_type_wr_dm = type_q;
  assign bus.wr_ins_dm       = wr_ins_q;
endmodule

// File: tb/tb_dm_amo_sequencer.sv
// Directed bench for dm_amo_sequencer: arithmetic/width cases, round-robin ties,
// read-port stall and mid-sequence reset.
module tb_dm_amo_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_asrt = 0;
  int   n_fail = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   both_cnt = 0;
  logic [63:0] wr_data_last = '0;
  logic [7:0]  wr_addr_last = '0;

  always #5 clk = ~clk;

  dm_amo_sequencer_if #(.DOUBLEWORD_WIDTH(64), .DATA_MEMORY_SIZE(256), .DATA_TYPE_WIDTH(2)) bus ();

  dm_amo_sequencer #(
    .DOUBLEWORD_WIDTH(64),
    .DATA_MEMORY_SIZE(256),
    .DATA_TYPE_WIDTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    if (bus.rd_ins_dm) rd_cnt <= rd_cnt + 1;
    if (bus.wr_ins_dm) begin
      wr_cnt       <= wr_cnt + 1;
      wr_data_last <= bus.data_bus_wr_dm;
      wr_addr_last <= bus.addr_wr_dm;
    end
    if (bus.rd_ins_dm && bus.wr_ins_dm) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits up to max cycles for a done pulse; cyc stays 0 on timeout.
  task automatic wait_done(input int max, output int cyc, output int act, output logic [1:0] who,
                           output logic [7:0] a1, output logic [1:0] t1);
    cyc = 0; act = 0; who = 2'b00; a1 = '0; t1 = '0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a1 = bus.addr_rd_dm;
        t1 = bus.data_type_rd_dm;
      end
      if (bus.amo_active) act++;
      if (bus.amo_done_p1 || bus.amo_done_p2) begin
        cyc = i;
        who = {bus.amo_done_p2, bus.amo_done_p1};
        break;
      end
    end
  endtask

  task automatic amo_p1(input string tag, input logic [2:0] op, input logic [1:0] ty,
                        input logic [7:0] addr, input logic [63:0] src, input logic [63:0] mem,
                        input logic [63:0] exp_wr, input logic [63:0] exp_old);
    int cyc, act, rd0, wr0;
    logic [1:0] who, t1;
    logic [7:0] a1;
    @(negedge clk);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.data_bus_rd_dm = mem;
    bus.amo_op_p1      = op;
    bus.amo_type_p1    = ty;
    bus.amo_addr_p1    = addr;
    bus.amo_src_p1     = src;
    bus.amo_req_p1     = 1'b1;
    wait_done(30, cyc, act, who, a1, t1);
    bus.amo_req_p1 = 1'b0;
    check({tag, "_lat"},    64'(cyc), 64'd8);
    check({tag, "_active"}, 64'(act), 64'd8);
    check({tag, "_who"},    64'(who), 64'd1);
    check({tag, "_raddr"},  64'(a1),  64'(addr));
    check({tag, "_rtype"},  64'(t1),  64'(ty));
    check({tag, "_old"},    bus.amo_old_p1, exp_old);
    check({tag, "_wdata"},  wr_data_last, exp_wr);
    check({tag, "_waddr"},  64'(wr_addr_last), 64'(addr));
    check({tag, "_nrd"},    64'(rd_cnt - rd0), 64'd1);
    check({tag, "_nwr"},    64'(wr_cnt - wr0), 64'd1);
  endtask

  initial begin
    int cyc, act, wr0;
    logic [1:0] who, t1;
    logic [7:0] a1;
    logic seen;

    rst = 1'b1;
    bus.amo_req_p1 = 1'b0; bus.amo_req_p2 = 1'b0;
    bus.amo_op_p1 = '0; bus.amo_op_p2 = '0;
    bus.amo_addr_p1 = '0; bus.amo_addr_p2 = '0;
    bus.amo_type_p1 = '0; bus.amo_type_p2 = '0;
    bus.amo_src_p1 = '0; bus.amo_src_p2 = '0;
    bus.data_bus_rd_dm = '0;
    bus.rd_idle_dm = 1'b1;
    bus.wr_idle_dm = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_active", 64'(bus.amo_active), 64'd0);
    check("rst_done",   64'({bus.amo_done_p2, bus.amo_done_p1}), 64'd0);
    check("rst_old_p1", bus.amo_old_p1, 64'd0);
    check("rst_old_p2", bus.amo_old_p2, 64'd0);
    check("rst_strobe", 64'({bus.rd_ins_dm, bus.wr_ins_dm}), 64'd0);
    check("rst_addr",   64'({bus.addr_rd_dm, bus.addr_wr_dm}), 64'd0);
    check("rst_type",   64'({bus.data_type_rd_dm, bus.data_type_wr_dm}), 64'd0);
    check("rst_wdata",  bus.data_bus_wr_dm, 64'd0);

    amo_p1("add_dw",   3'b001, 2'b11, 8'h10, 64'd3, 64'd5, 64'd8, 64'd5);
    amo_p1("max_w",    3'b101, 2'b10, 8'h20, 64'd1, 64'h0000_0000_FFFF_FFFF,
           64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    amo_p1("maxu_w",   3'b111, 2'b10, 8'h20, 64'd1, 64'h0000_0000_FFFF_FFFF,
           64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    amo_p1("add_b",    3'b001, 2'b00, 8'h03, 64'd1, 64'h0000_0000_0000_00FF,
           64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    amo_p1("min_h",    3'b110, 2'b01, 8'h06, 64'd5, 64'h0000_0000_0000_8000,
           64'h0000_0000_0000_8000, 64'hFFFF_FFFF_FFFF_8000);
    amo_p1("xor_w",    3'b100, 2'b10, 8'h40, 64'hAAAA_AAAA_0F0F_0F0F, 64'h1234_5678_F0F0_F0F0,
           64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_F0F0_F0F0);
    amo_p1("and_dw",   3'b010, 2'b11, 8'h48, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFF00_FF00_FF00_FF00,
           64'h0F00_0F00_0F00_0F00, 64'hFF00_FF00_FF00_FF00);
    amo_p1("or_h",     3'b011, 2'b01, 8'h50, 64'h0000_0000_00F0_0001, 64'h0000_0000_0000_1234,
           64'h0000_0000_0000_1235, 64'h0000_0000_0000_1234);
    amo_p1("max_dw",   3'b101, 2'b11, 8'h58, 64'd7, 64'h8000_0000_0000_0000,
           64'd7, 64'h8000_0000_0000_0000);
    amo_p1("swap_b",   3'b000, 2'b00, 8'h60, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0042,
           64'h0000_0000_0000_00F0, 64'h0000_0000_0000_0042);

    // Round-robin: fresh reset so last grant is P2 and P1 wins the first tie.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.amo_op_p1 = 3'b000; bus.amo_type_p1 = 2'b11; bus.amo_addr_p1 = 8'h20;
    bus.amo_src_p1 = 64'h1111_1111_1111_1111;
    bus.amo_op_p2 = 3'b000; bus.amo_type_p2 = 2'b11; bus.amo_addr_p2 = 8'h28;
    bus.amo_src_p2 = 64'h2222_2222_2222_2222;
    bus.data_bus_rd_dm = 64'h5555_5555_5555_5555;
    bus.amo_req_p1 = 1'b1; bus.amo_req_p2 = 1'b1;
    wait_done(30, cyc, act, who, a1, t1);
    check("tie1_lat",   64'(cyc), 64'd8);
    check("tie1_who",   64'(who), 64'd1);
    check("tie1_old",   bus.amo_old_p1, 64'h5555_5555_5555_5555);
    check("tie1_wdata", wr_data_last, 64'h1111_1111_1111_1111);
    check("tie1_waddr", 64'(wr_addr_last), 64'h20);
    bus.data_bus_rd_dm = 64'h1111_1111_1111_1111;
    wait_done(30, cyc, act, who, a1, t1);
    check("tie2_lat",   64'(cyc), 64'd9);
    check("tie2_who",   64'(who), 64'd2);
    check("tie2_old",   bus.amo_old_p2, 64'h1111_1111_1111_1111);
    check("tie2_wdata", wr_data_last, 64'h2222_2222_2222_2222);
    check("tie2_waddr", 64'(wr_addr_last), 64'h28);
    check("tie2_hold1", bus.amo_old_p1, 64'h5555_5555_5555_5555);
    bus.amo_req_p2 = 1'b0;
    bus.data_bus_rd_dm = 64'h2222_2222_2222_2222;
    wait_done(30, cyc, act, who, a1, t1);
    bus.amo_req_p1 = 1'b0;
    check("tie3_lat",   64'(cyc), 64'd9);
    check("tie3_who",   64'(who), 64'd1);
    check("tie3_old",   bus.amo_old_p1, 64'h2222_2222_2222_2222);

    // Read port stalls for 5 cycles in RD_WAIT.
    @(negedge clk);
    @(negedge clk);
    bus.amo_op_p2 = 3'b001; bus.amo_type_p2 = 2'b11; bus.amo_addr_p2 = 8'h30;
    bus.amo_src_p2 = 64'd20;
    bus.data_bus_rd_dm = 64'd10;
    bus.amo_req_p2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_rdins", 64'(bus.rd_ins_dm), 64'd1);
    bus.rd_idle_dm = 1'b0;
    bus.data_bus_rd_dm = 64'hDEAD_BEEF_DEAD_BEEF;
    seen = 1'b0;
    for (int i = 3; i <= 8; i++) begin
      @(negedge clk);
      if (bus.amo_done_p2 || bus.amo_done_p1) seen = 1'b1;
    end
    check("stall_nodone", 64'(seen), 64'd0);
    bus.rd_idle_dm = 1'b1;
    bus.data_bus_rd_dm = 64'd10;
    wait_done(30, cyc, act, who, a1, t1);
    bus.amo_req_p2 = 1'b0;
    check("stall_lat",   64'(cyc), 64'd5);
    check("stall_who",   64'(who), 64'd2);
    check("stall_old",   bus.amo_old_p2, 64'd10);
    check("stall_wdata", wr_data_last, 64'd30);

    // Reset while in WR_GAP.
    @(negedge clk);
    wr0 = wr_cnt;
    bus.amo_op_p1 = 3'b001; bus.amo_type_p1 = 2'b11; bus.amo_addr_p1 = 8'h38;
    bus.amo_src_p1 = 64'd1;
    bus.data_bus_rd_dm = 64'd1;
    bus.amo_req_p1 = 1'b1;
    repeat (6) @(negedge clk);
    check("rstmid_wrins", 64'(bus.wr_ins_dm), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.amo_req_p1 = 1'b0;
    check("rstmid_active", 64'(bus.amo_active), 64'd0);
    check("rstmid_done",   64'({bus.amo_done_p2, bus.amo_done_p1}), 64'd0);
    check("rstmid_strobe", 64'({bus.rd_ins_dm, bus.wr_ins_dm}), 64'd0);
    check("rstmid_addr",   64'({bus.addr_rd_dm, bus.addr_wr_dm}), 64'd0);
    check("rstmid_old2",   bus.amo_old_p2, 64'd0);
    check("rstmid_wdata",  bus.data_bus_wr_dm, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.amo_done_p1 || bus.amo_done_p2 || bus.amo_active || bus.wr_ins_dm) seen = 1'b1;
    end
    check("rstmid_quiet", 64'(seen), 64'd0);
    check("rstmid_nwr",   64'(wr_cnt - wr0), 64'd1);

    bus.amo_src_p2 = 64'd100;
    bus.data_bus_rd_dm = 64'd7;
    bus.amo_req_p1 = 1'b1; bus.amo_req_p2 = 1'b1;
    wait_done(30, cyc, act, who, a1, t1);
    bus.amo_req_p1 = 1'b0; bus.amo_req_p2 = 1'b0;
    check("post_lat",   64'(cyc), 64'd8);
    check("post_who",   64'(who), 64'd1);
    check("post_old",   bus.amo_old_p1, 64'd7);
    check("post_wdata", wr_data_last, 64'd8);
    repeat (3) @(negedge clk);
    check("no_dual_strobe", 64'(both_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
